watch_mode_ctrl: RTL and testbench

Mode controller for the digital watch. It shares the single 10-key keypad and the 6-digit display between three activities: time keeping, time setting and alarm setting. It also runs the alarm ring/snooze sequence. It buffers and validates keypad digits, then commits them to the time counter or the alarm register with one load pulse. It sits between the keypad/DIP inputs and the time-counter, alarm-register and display-mux blocks.

---
 rtl/watch_pkg.sv | 52 +++++
 rtl/watch_mode_ctrl_key_edge.sv | 26 ++
 rtl/watch_mode_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_watch_mode_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Shared types and constants for the watch mode controller.
// Digit limits, digit counts, LED patterns and entry helpers.
package watch_pkg;

  typedef enum logic [2:0] {
    S_CLOCK,
    S_SET_TIME,
    S_SET_ALARM,
    S_RINGING,
    S_SNOOZE
  } state_t;

  localparam logic [3:0] LIM_2 = 4'd2;
  localparam logic [3:0] LIM_3 = 4'd3;
  localparam logic [3:0] LIM_5 = 4'd5;
  localparam logic [3:0] LIM_9 = 4'd9;

  localparam logic [2:0] TIME_DIGITS  = 3'd6;
  localparam logic [2:0] ALARM_DIGITS = 3'd4;

  localparam logic [7:0] LED_ON  = 8'hFF;
  localparam logic [7:0] LED_OFF = 8'h00;

  // Hour tens digit caps the hour ones digit (20..23).
  function automatic logic digit_ok(
    input logic [2:0] idx,
    input logic [3:0] d,
    input logic [3:0] d0
  );
    logic [3:0] lim;
    unique case (idx)
      3'd0:       lim = LIM_2;
      3'd1:       lim = (d0 == LIM_2) ? LIM_3 : LIM_9;
      3'd2, 3'd4: lim = LIM_5;
      default:    lim = LIM_9;
    endcase
    return d <= lim;
  endfunction

  function automatic logic [23:0] set_digit(
    input logic [23:0] e,
    input logic [2:0]  idx,
    input logic [3:0]  d
  );
    logic [23:0] r;
    r = e;
    for (int i = 0; i < 6; i++)
      if (idx == 3'(i)) r[23-4*i -: 4] = d;
    return r;
  endfunction

endpackage

// File: rtl/watch_mode_ctrl_key_edge.sv
// Keypad press detector: one-hot key after an all-released keypad.
// Chords are ignored and leave no pending press behind.
module key_edge (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] keypad,
  output logic       key_evt,
  output logic [3:0] key_val
);

  logic [9:0] prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= '0;
    else     prev <= keypad;
  end

  assign key_evt = $onehot(keypad) && (prev == '0);

  always_comb begin
    key_val = '0;
    for (int i = 0; i < 10; i++)
      if (keypad[i]) key_val = 4'(i);
  end

endmodule

// File: rtl/watch_mode_ctrl.sv
// Watch mode controller: keypad entry, time/alarm loads,
// alarm ring and snooze sequencing.
module watch_mode_ctrl
  import watch_pkg::*;
#(
  parameter int CLK_HZ     = 1000,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int BLINK_MS   = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode_btn,
  input  logic [9:0]  keypad,
  input  logic        alarm_match,
  output logic [23:0] entry,
  output logic        time_load,
  output logic        alarm_load,
  output logic        alarm_armed,
  output logic        clock_run,
  output logic        disp_sel,
  output logic [2:0]  entry_idx,
  output logic        key_err,
  output logic [7:0]  leds
);

  localparam int RING_CYC  = CLK_HZ * RING_SEC;
  localparam int SNZ_CYC   = CLK_HZ * SNOOZE_SEC;
  localparam int BLINK_CYC = CLK_HZ * BLINK_MS / 1000;
  localparam int TMR_MAX   = (RING_CYC > SNZ_CYC) ? RING_CYC : SNZ_CYC;
  localparam int TMR_W     = $clog2(TMR_MAX);
  localparam int BLK_W     = $clog2(BLINK_CYC + 1);

  state_t state, nxt;

  logic             mode_q, am_q;
  logic             mode_evt, am_evt;
  logic             key_evt;
  logic [3:0]       key_val;
  logic             pend, pend_d;
  logic [TMR_W-1:0] tmr;
  logic [BLK_W-1:0] blk;
  logic             tmr_zero, blink_end;
  logic             key_ok, last;

  logic [23:0] entry_d;
  logic [2:0]  idx_d;
  logic        tl_d, al_d, armed_d, run_d, dsel_d, kerr_d;
  logic [7:0]  leds_d;

  key_edge u_key (
    .clk     (clk),
    .rst     (rst),
    .keypad  (keypad),
    .key_evt (key_evt),
    .key_val (key_val)
  );

  assign mode_evt  = mode_btn & ~mode_q;
  assign am_evt    = alarm_match & ~am_q;
  assign tmr_zero  = (tmr == '0);
  assign blink_end = (blk == BLK_W'(BLINK_CYC - 1));
  assign key_ok    = digit_ok(entry_idx, key_val, entry[23:20]);
  assign last      = (state == S_SET_TIME)
                   ? (entry_idx == TIME_DIGITS - 3'd1)
                   : (entry_idx == ALARM_DIGITS - 3'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_CLOCK;
      entry       <= '0;
      entry_idx   <= '0;
      time_load   <= 1'b0;
      alarm_load  <= 1'b0;
      alarm_armed <= 1'b0;
      clock_run   <= 1'b1;
      disp_sel    <= 1'b0;
      key_err     <= 1'b0;
      leds        <= LED_OFF;
      pend        <= 1'b0;
    end else begin
      state       <= nxt;
      entry       <= entry_d;
      entry_idx   <= idx_d;
      time_load   <= tl_d;
      alarm_load  <= al_d;
      alarm_armed <= armed_d;
      clock_run   <= run_d;
      disp_sel    <= dsel_d;
      key_err     <= kerr_d;
      leds        <= leds_d;
      pend        <= pend_d;
    end
  end

  // One timer serves ring and snooze; any state change reloads it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= 1'b0;
      am_q   <= 1'b0;
      tmr    <= '0;
      blk    <= '0;
    end else begin
      mode_q <= mode_btn;
      am_q   <= alarm_match;
      if (nxt != state)
        tmr <= (nxt == S_SNOOZE) ? TMR_W'(SNZ_CYC - 1)
                                 : TMR_W'(RING_CYC - 1);
      else if (!tmr_zero)
        tmr <= tmr - 1'b1;
      if (nxt == S_RINGING && state == S_RINGING)
        blk <= blink_end ? '0 : blk + 1'b1;
      else
        blk <= '0;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_CLOCK:
        if (mode_evt)                nxt = S_SET_TIME;
        else if (am_evt && alarm_armed) nxt = S_RINGING;
      S_SET_TIME:
        if (pend)                    nxt = S_CLOCK;
        else if (mode_evt)           nxt = S_SET_ALARM;
      S_SET_ALARM:
        if (pend || mode_evt)        nxt = S_CLOCK;
      S_RINGING:
        if (mode_evt)                nxt = S_CLOCK;
        else if (key_evt)            nxt = S_SNOOZE;
        else if (tmr_zero)           nxt = S_CLOCK;
      S_SNOOZE:
        if (mode_evt)                nxt = S_CLOCK;
        else if (tmr_zero)           nxt = S_RINGING;
      default:                       nxt = S_CLOCK;
    endcase
  end

  always_comb begin
    entry_d = entry;
    idx_d   = entry_idx;
    tl_d    = 1'b0;
    al_d    = 1'b0;
    armed_d = alarm_armed;
    kerr_d  = 1'b0;
    pend_d  = 1'b0;
    run_d   = (nxt != S_SET_TIME);
    dsel_d  = (nxt == S_SET_TIME) || (nxt == S_SET_ALARM);
    leds_d  = LED_OFF;
    if (nxt == S_RINGING) begin
      if (state != S_RINGING) leds_d = LED_ON;
      else if (blink_end)     leds_d = ~leds;
      else                    leds_d = leds;
    end
    unique case (state)
      S_CLOCK:
        if (mode_evt) begin
          entry_d = '0;
          idx_d   = '0;
        end
      S_SET_TIME, S_SET_ALARM:
        if (pend) begin
          tl_d = (state == S_SET_TIME);
          al_d = (state == S_SET_ALARM);
          if (state == S_SET_ALARM) armed_d = 1'b1;
        end else if (mode_evt) begin
          entry_d = '0;
          idx_d   = '0;
          if (state == S_SET_ALARM && entry_idx == '0)
            armed_d = 1'b0;
        end else if (key_evt) begin
          if (key_ok) begin
            entry_d = set_digit(entry, entry_idx, key_val);
            if (last) pend_d = 1'b1;
            else      idx_d  = entry_idx + 3'd1;
          end else begin
            kerr_d = 1'b1;
          end
        end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_watch_mode_ctrl.sv
// Self-checking bench for watch_mode_ctrl with scaled-down timing.
// Per-cycle behavioural model plus directed literal checks.
module tb_watch_mode_ctrl;

  localparam int CLK_HZ = 100;
  localparam int RING   = 200;
  localparam int SNZ    = 300;
  localparam int BLINK  = 5;

  logic        clk = 0;
  logic        rst = 0;
  logic        mode_btn = 0;
  logic [9:0]  keypad = '0;
  logic        alarm_match = 0;
  logic [23:0] entry;
  logic        time_load, alarm_load, alarm_armed;
  logic        clock_run, disp_sel, key_err;
  logic [2:0]  entry_idx;
  logic [7:0]  leds;

  int checks = 0;
  int errors = 0;
  bit go = 0;
  int tl_cnt = 0, al_cnt = 0, kerr_cnt = 0;

  watch_mode_ctrl #(
    .CLK_HZ(CLK_HZ), .RING_SEC(2), .SNOOZE_SEC(3), .BLINK_MS(50)
  ) dut (
    .clk(clk), .rst(rst), .mode_btn(mode_btn), .keypad(keypad),
    .alarm_match(alarm_match), .entry(entry), .time_load(time_load),
    .alarm_load(alarm_load), .alarm_armed(alarm_armed),
    .clock_run(clock_run), .disp_sel(disp_sel), .entry_idx(entry_idx),
    .key_err(key_err), .leds(leds)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: activity 0 clock, 1 set time, 2 set alarm, 3 ring, 4 snooze
  int m, n, age, dig[6], lim[6];
  bit armed, due;
  logic [9:0] pk;
  bit pm, pa;
  bit e_tl, e_al, e_kerr;

  always @(posedge clk or posedge rst) begin
    bit kev, mev, aev;
    int kv, nm, ndig;
    if (rst) begin
      m = 0; n = 0; age = 0; armed = 0; due = 0;
      foreach (dig[i]) dig[i] = 0;
      pk = '0; pm = 0; pa = 0;
      e_tl = 0; e_al = 0; e_kerr = 0;
    end else begin
      kev = ($countones(keypad) == 1) && (pk == '0);
      kv = 0;
      for (int i = 0; i < 10; i++) if (keypad[i]) kv = i;
      mev = mode_btn && !pm;
      aev = alarm_match && !pa;
      pk = keypad; pm = mode_btn; pa = alarm_match;
      e_tl = 0; e_al = 0; e_kerr = 0;
      lim = '{2, (dig[0] == 2) ? 3 : 9, 5, 9, 5, 9};
      ndig = (m == 1) ? 6 : 4;
      nm = m;
      case (m)
        0: if (mev) begin
             nm = 1; n = 0;
             foreach (dig[i]) dig[i] = 0;
           end else if (aev && armed) nm = 3;
        1, 2: if (due) begin
             due = 0; nm = 0;
             if (m == 1) e_tl = 1;
             else begin e_al = 1; armed = 1; end
           end else if (mev) begin
             if (m == 2 && n == 0) armed = 0;
             nm = (m == 1) ? 2 : 0;
             n = 0;
             foreach (dig[i]) dig[i] = 0;
           end else if (kev) begin
             if (kv <= lim[n]) begin
               dig[n] = kv;
               if (n == ndig - 1) due = 1;
               else n++;
             end else e_kerr = 1;
           end
        3: if (mev) nm = 0;
           else if (kev) nm = 4;
           else if (age == RING - 1) nm = 0;
        4: if (mev) nm = 0;
           else if (age == SNZ - 1) nm = 3;
        default: nm = 0;
      endcase
      age = (nm != m) ? 0 : age + 1;
      m = nm;
    end
  end

  function automatic logic [23:0] e_entry();
    logic [23:0] r;
    for (int i = 0; i < 6; i++) r[23-4*i -: 4] = 4'(dig[i]);
    return r;
  endfunction

  always @(negedge clk) begin
    if (go && !rst) begin
      chk("entry", entry, e_entry());
      chk("entry_idx", entry_idx, n);
      chk("time_load", time_load, e_tl);
      chk("alarm_load", alarm_load, e_al);
      chk("key_err", key_err, e_kerr);
      chk("alarm_armed", alarm_armed, armed);
      chk("clock_run", clock_run, m != 1);
      chk("disp_sel", disp_sel, m == 1 || m == 2);
      chk("leds", leds,
          (m == 3 && (age / BLINK) % 2 == 0) ? 8'hFF : 8'h00);
      if (time_load)  tl_cnt++;
      if (alarm_load) al_cnt++;
      if (key_err)    kerr_cnt++;
    end
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  task automatic press(input int d);
    keypad = 10'(1 << d);
    tick(1);
    keypad = '0;
    tick(1);
  endtask

  task automatic mode();
    mode_btn = 1;
    tick(1);
    mode_btn = 0;
    tick(1);
  endtask

  task automatic set_alarm_0730();
    mode(); mode();
    press(0); press(7); press(3); press(0);
    tick(2);
  endtask

  initial begin
    #1 rst = 1;
    #1;
    chk("rst_entry", entry, 0);
    chk("rst_idx", entry_idx, 0);
    chk("rst_leds", leds, 0);
    chk("rst_run", clock_run, 1);
    chk("rst_dsel", disp_sel, 0);
    chk("rst_armed", alarm_armed, 0);
    tick(3);
    rst = 0;
    go = 1;
    tick(2);

    // time entry with rejected digit and ignored chord
    mode();
    chk("st_run", clock_run, 0);
    chk("st_dsel", disp_sel, 1);
    keypad = 10'b11; tick(1);
    keypad = 10'b01; tick(1);
    keypad = '0;     tick(1);
    chk("chord_idx", entry_idx, 0);
    press(2); press(4);
    chk("err_idx", entry_idx, 1);
    chk("err_cnt", kerr_cnt, 1);
    press(3);
    chk("ok_idx", entry_idx, 2);
    press(5); press(9); press(5); press(8);
    tick(2);
    chk("time_entry", entry, 24'h235958);
    chk("tl_cnt", tl_cnt, 1);
    chk("post_run", clock_run, 1);
    chk("post_dsel", disp_sel, 0);

    // alarm entry then ring/blink
    set_alarm_0730();
    chk("al_cnt", al_cnt, 1);
    chk("al_entry", entry[23:8], 16'h0730);
    chk("al_armed", alarm_armed, 1);
    alarm_match = 1;
    tick(1);
    chk("ring_on0", leds, 8'hFF);
    tick(5);
    chk("ring_off", leds, 8'h00);
    tick(5);
    chk("ring_on1", leds, 8'hFF);
    alarm_match = 0;

    // snooze and re-ring, then auto-dismiss
    press(1);
    chk("snz_leds", leds, 8'h00);
    tick(298);
    chk("snz_end", leds, 8'h00);
    tick(1);
    chk("rering", leds, 8'hFF);
    tick(194);
    chk("ring_late", leds, 8'hFF);
    tick(6);
    chk("dismiss", leds, 8'h00);
    tick(5);
    chk("dismiss2", leds, 8'h00);
    chk("still_armed", alarm_armed, 1);

    // abort with mode/key collision
    mode();
    press(1); press(2); press(3);
    mode_btn = 1; keypad = 10'(1 << 4);
    tick(1);
    mode_btn = 0; keypad = '0;
    tick(2);
    chk("ab_tl", tl_cnt, 1);
    chk("ab_entry", entry, 0);
    chk("ab_idx", entry_idx, 0);
    chk("ab_dsel", disp_sel, 1);
    chk("ab_run", clock_run, 1);
    mode();
    chk("disarm", alarm_armed, 0);
    chk("disarm_dsel", disp_sel, 0);

    // async reset while ringing
    set_alarm_0730();
    chk("rearm", alarm_armed, 1);
    alarm_match = 1;
    tick(3);
    chk("ring2", leds, 8'hFF);
    #3 rst = 1;
    #1;
    chk("ar_leds", leds, 8'h00);
    chk("ar_armed", alarm_armed, 0);
    chk("ar_run", clock_run, 1);
    chk("ar_dsel", disp_sel, 0);
    chk("ar_entry", entry, 0);
    chk("ar_tl", tl_cnt, 1);
    alarm_match = 0;
    tick(2);
    rst = 0;
    tick(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
